// File: rtl/vreg_wb_if.sv
// Write-back bus for vreg_wb_arb: two requesters (ALU, load), issue port,
// registered register-file write port and the pending-write scoreboard.
interface vreg_wb_if #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
);
  logic              A_VALID;
  logic [4:0]        A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic              A_READY;
  logic              L_VALID;
  logic [4:0]        L_ADDR;
  logic [DATA_W-1:0] L_DATA;
  logic              L_READY;
  logic              ISSUE_EN;
  logic [4:0]        ISSUE_ADDR;
  logic              D_EN;
  logic [4:0]        D_Addr;
  logic [DATA_W-1:0] D;
  logic [NREG-1:0]   BUSY;
  logic              dbg_last_l;

  modport slave (
    input  A_VALID, A_ADDR, A_DATA, L_VALID, L_ADDR, L_DATA, ISSUE_EN, ISSUE_ADDR,
    output A_READY, L_READY, D_EN, D_Addr, D, BUSY, dbg_last_l
  );

  modport master (
    output A_VALID, A_ADDR, A_DATA, L_VALID, L_ADDR, L_DATA, ISSUE_EN, ISSUE_ADDR,
    input  A_READY, L_READY, D_EN, D_Addr, D, BUSY, dbg_last_l
  );
endinterface

// File: rtl/vreg_wb_arb.sv
// Round-robin write-back arbiter between ALU and load unit, with a registered
// register-file write port and a per-register pending-write scoreboard.
module vreg_wb_arb #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input logic      CLK,
  input logic      RESET,
  vreg_wb_if.slave bus
);
  localparam int AW = 5;

  // Handshake: a transfer happens on a rising edge where VALID and READY are
  // both high; the requester keeps VALID/ADDR/DATA stable until then. READY
  // never rises without VALID and never while RESET is high.
  logic              last_l;   // 1: load was granted most recently (ALU wins next tie)
  logic              a_gnt;
  logic              l_gnt;
  logic              acc;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;

  logic              d_en_q;
  logic [AW-1:0]     d_addr_q;
  logic [DATA_W-1:0] d_q;
  logic [NREG-1:0]   busy_q;

  always_comb begin
    a_gnt    = !RESET && bus.A_VALID && (!bus.L_VALID || last_l);
    l_gnt    = !RESET && bus.L_VALID && !a_gnt;
    acc      = a_gnt || l_gnt;
    acc_addr = a_gnt ? bus.A_ADDR : bus.L_ADDR;
    acc_data = a_gnt ? bus.A_DATA : bus.L_DATA;
    set_vec  = '0;
    clr_vec  = '0;
    for (int i = 0; i < NREG; i++) begin
      set_vec[i] = bus.ISSUE_EN && (bus.ISSUE_ADDR == AW'(i));
      clr_vec[i] = acc && (acc_addr == AW'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_l   <= 1'b1;
      d_en_q   <= 1'b0;
      d_addr_q <= '0;
      d_q      <= '0;
      busy_q   <= '0;
    end else begin
      d_en_q <= acc;
      if (acc) begin
        d_addr_q <= acc_addr;
        d_q      <= acc_data;
        last_l   <= l_gnt;
      end
      // Set applied after clear so a same-address issue marks the newer write.
      busy_q <= (busy_q & ~clr_vec) | set_vec;
    end
  end

  // Outputs read as zero for the whole reset cycle, including a write
  // registered on the edge just before RESET rose.
  assign bus.A_READY    = a_gnt;
  assign bus.L_READY    = l_gnt;
  assign bus.D_EN       = d_en_q && !RESET;
  assign bus.D_Addr     = RESET ? '0 : d_addr_q;
  assign bus.D          = RESET ? '0 : d_q;
  assign bus.BUSY       = RESET ? '0 : busy_q;
  assign bus.dbg_last_l = last_l;
endmodule

// File: tb/tb_vreg_wb_arb.sv
// Bench for vreg_wb_arb: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model and write queue.
module tb_vreg_wb_arb;
  localparam int DW = 64;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vreg_wb_if #(.DATA_W(DW), .NREG(NR)) bus ();
  vreg_wb_arb #(.DATA_W(DW), .NREG(NR)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic              m_last_l = 1'b1;
  logic              m_den    = 1'b0;
  logic [4:0]        m_addr   = '0;
  logic [DW-1:0]     m_d      = '0;
  logic [NR-1:0]     m_busy   = '0;
  logic [5+DW-1:0]   exp_q[$];
  logic              ga, gl, a_acc, l_acc;

  // Observed values captured mid-cycle by step()
  logic              obs_a, obs_l, obs_den, obs_last;
  logic [4:0]        obs_daddr;
  logic [DW-1:0]     obs_d;
  logic [NR-1:0]     obs_busy;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check at negedge, then advance the model on the rising edge.
  task automatic step();
    logic [5+DW-1:0] e;
    @(negedge clk);
    if (rst) begin
      ga = 1'b0; gl = 1'b0;
    end else if (bus.A_VALID && bus.L_VALID) begin
      ga = m_last_l; gl = !m_last_l;
    end else begin
      ga = bus.A_VALID; gl = bus.L_VALID;
    end
    obs_a = bus.A_READY; obs_l = bus.L_READY; obs_den = bus.D_EN;
    obs_daddr = bus.D_Addr; obs_d = bus.D; obs_busy = bus.BUSY; obs_last = bus.dbg_last_l;
    chk("a_ready", obs_a, ga);
    chk("l_ready", obs_l, gl);
    chk("d_en", obs_den, rst ? 1'b0 : m_den);
    chk("d_addr", obs_daddr, rst ? 5'd0 : m_addr);
    chk("d_data", obs_d, rst ? '0 : m_d);
    chk("busy", obs_busy, rst ? '0 : m_busy);
    if (!rst) chk("last_l", obs_last, m_last_l);
    if (!rst && m_den) begin
      if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("q_addr", obs_daddr, e[5+DW-1:DW]);
        chk("q_data", obs_d, e[DW-1:0]);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_den = 0; m_addr = 0; m_d = 0; m_busy = 0; m_last_l = 1; exp_q.delete();
    end else begin
      m_den = ga || gl;
      if (ga) begin
        exp_q.push_back({bus.A_ADDR, bus.A_DATA});
        m_addr = bus.A_ADDR; m_d = bus.A_DATA; m_last_l = 0; m_busy[bus.A_ADDR] = 1'b0;
      end else if (gl) begin
        exp_q.push_back({bus.L_ADDR, bus.L_DATA});
        m_addr = bus.L_ADDR; m_d = bus.L_DATA; m_last_l = 1; m_busy[bus.L_ADDR] = 1'b0;
      end
      if (bus.ISSUE_EN) m_busy[bus.ISSUE_ADDR] = 1'b1;
    end
    a_acc = ga; l_acc = gl;
    #1;
  endtask

  task automatic drive_idle();
    bus.A_VALID = 0; bus.L_VALID = 0; bus.ISSUE_EN = 0;
  endtask

  task automatic drive_random();
    if (!bus.A_VALID || a_acc) begin
      bus.A_VALID = ($urandom_range(0, 2) != 0);
      bus.A_ADDR  = 5'($urandom_range(0, 7));
      bus.A_DATA  = {$urandom, $urandom};
    end
    if (!bus.L_VALID || l_acc) begin
      bus.L_VALID = ($urandom_range(0, 2) != 0);
      bus.L_ADDR  = 5'($urandom_range(0, 7));
      bus.L_DATA  = {$urandom, $urandom};
    end
    bus.ISSUE_EN   = ($urandom_range(0, 2) == 0);
    bus.ISSUE_ADDR = 5'($urandom_range(0, 7));
    rst = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    logic [4:0]    hold_addr;
    logic [DW-1:0] hold_d;
    logic          hold_last;
    int            pulses;
    bus.A_ADDR = 0; bus.A_DATA = 0; bus.L_ADDR = 0; bus.L_DATA = 0; bus.ISSUE_ADDR = 0;
    drive_idle();
    a_acc = 0; l_acc = 0;
    rst = 1;
    step(); step();
    rst = 0;

    // Tie under continuous contention alternates starting with the ALU
    bus.A_VALID = 1; bus.A_ADDR = 5'd3; bus.A_DATA = 64'h0000_0000_0000_0033;
    bus.L_VALID = 1; bus.L_ADDR = 5'd7; bus.L_DATA = 64'h0000_0000_0000_0077;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_a_gnt", obs_a, (i % 2) == 0);
      if (i > 0) begin
        chk("tie_d_en", obs_den, 1);
        chk("tie_d_addr", obs_daddr, (i % 2) == 1 ? 5'd3 : 5'd7);
      end
    end
    drive_idle();
    step();
    chk("tie_last_addr", obs_daddr, 5'd7);

    // Issue then write-back of the same register clears its busy bit
    bus.ISSUE_EN = 1; bus.ISSUE_ADDR = 5'd5;
    step();
    bus.ISSUE_EN = 0;
    bus.L_VALID = 1; bus.L_ADDR = 5'd5; bus.L_DATA = 64'hDEAD_BEEF_0000_0001;
    step();
    chk("issue_busy", obs_busy, 32'h0000_0020);
    drive_idle();
    step();
    chk("ld_d_en", obs_den, 1);
    chk("ld_data", obs_d, 64'hDEAD_BEEF_0000_0001);
    chk("ld_busy_clr", obs_busy, 0);

    // Same-cycle issue and write to the same register keeps it busy
    bus.ISSUE_EN = 1; bus.ISSUE_ADDR = 5'd9;
    step();
    bus.A_VALID = 1; bus.A_ADDR = 5'd9; bus.A_DATA = 64'h99;
    step();
    drive_idle();
    step();
    chk("same_busy9", obs_busy[9], 1);
    chk("same_d_addr", obs_daddr, 5'd9);

    // ALU alone gets one write per cycle
    pulses = 0;
    bus.A_VALID = 1;
    for (int i = 0; i < 5; i++) begin
      bus.A_ADDR = 5'(10 + i); bus.A_DATA = 64'(i);
      step();
      chk("solo_a_ready", obs_a, 1);
      chk("solo_l_ready", obs_l, 0);
      if (i > 0 && obs_den) pulses++;
    end
    drive_idle();
    step();
    if (obs_den) pulses++;
    chk("solo_pulses", pulses, 5);

    // Idle cycles hold the write port and the pointer
    hold_addr = obs_daddr; hold_d = obs_d; hold_last = obs_last;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", obs_a | obs_l, 0);
      chk("idle_d_en", obs_den, 0);
      chk("idle_addr", obs_daddr, hold_addr);
      chk("idle_data", obs_d, hold_d);
      chk("idle_last", obs_last, hold_last);
    end

    // Reset right after an accepted transfer discards it
    bus.L_VALID = 1; bus.L_ADDR = 5'd4; bus.L_DATA = 64'h44;
    step();
    drive_idle();
    rst = 1;
    step();
    chk("rst_d_en", obs_den, 0);
    chk("rst_busy", obs_busy, 0);
    rst = 0;
    bus.A_VALID = 1; bus.A_ADDR = 5'd1; bus.L_VALID = 1; bus.L_ADDR = 5'd2;
    step();
    chk("rst_tie_a", obs_a, 1);
    drive_idle();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end
    rst = 0;
    drive_idle();
    step(); step();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vreg_wb_arb.md
VREG_WB_ARB -- requirements
Module: vreg_wb_arb

Interface
REQ-001 Parameter DATA_W, default 64, write-data width in bits.
REQ-002 Parameter NREG, default 32, number of vector registers; address width is 5 bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-005 A_VALID  input  1  ALU write-back request valid.
REQ-006 A_ADDR  input  5  ALU destination register.
REQ-007 A_DATA  input  DATA_W  ALU write-back data.
REQ-008 A_READY  output  1  ALU request accepted this cycle.
REQ-009 L_VALID  input  1  load-unit write-back request valid.
REQ-010 L_ADDR  input  5  load destination register.
REQ-011 L_DATA  input  DATA_W  load write-back data.
REQ-012 L_READY  output  1  load request accepted this cycle.
REQ-013 ISSUE_EN  input  1  an instruction with a vector destination issues this cycle.
REQ-014 ISSUE_ADDR  input  5  destination register of the issuing instruction.
REQ-015 D_EN  output  1  register-file write enable, registered.
REQ-016 D_Addr  output  5  register-file write address, registered.
REQ-017 D  output  DATA_W  register-file write data, registered.
REQ-018 BUSY  output  NREG  scoreboard; bit n = write to register n pending.

Function
REQ-019 A_READY and L_READY SHALL be combinational from the VALID inputs and the priority pointer.
REQ-020 At most one READY SHALL be high per cycle, and a READY SHALL never be high while its VALID is low.
- One requester valid: that requester is granted.
- Both valid: the requester not granted most recently is granted.
- Neither valid: no grant; the pointer holds.
REQ-021 The priority pointer SHALL update only on an accepted transfer (VALID and READY both high), recording the granted requester.
REQ-022 An accepted transfer SHALL produce D_EN=1 with the granted ADDR/DATA on D_Addr/D in the next cycle; latency is exactly 1 cycle.
REQ-023 D_EN SHALL be 0 in any cycle following a cycle with no accepted transfer; D_Addr and D SHALL hold their last values.
REQ-024 A requester whose VALID stays high under continuous contention SHALL wait at most 1 cycle for a grant.
REQ-025 A requester SHALL hold VALID, ADDR and DATA stable until READY; the block is not required to tolerate withdrawal.
REQ-026 ISSUE_EN=1 SHALL set BUSY[ISSUE_ADDR] on the next edge.
REQ-027 An accepted transfer to address n SHALL clear BUSY[n] on the same edge that registers the write.
REQ-028 ISSUE and accepted transfer to the same address in the same cycle SHALL leave BUSY[n]=1 (the set wins, marking the newer pending write).
REQ-029 ISSUE and accepted transfer to different addresses in the same cycle SHALL take effect independently.
REQ-030 A transfer to a register whose BUSY bit is 0 SHALL still be written, and BUSY SHALL remain 0; no error is flagged.
REQ-031 The block SHALL never generate two writes from one accepted transfer.
REQ-032 A single requester valid every cycle SHALL be granted every cycle, giving one write per cycle of throughput.

Reset
REQ-033 While RESET=1: D_EN=0, D_Addr=0, D=0, BUSY=0, and the pointer is set so the ALU wins the first tie.
REQ-034 Requests and ISSUE_EN SHALL be ignored in any cycle where RESET=1, and RESET SHALL dominate all simultaneous events.
REQ-035 A transfer accepted in the cycle before RESET asserts SHALL be discarded, with D_EN=0 in the reset cycle.

Verification
REQ-036 Reset, then A_VALID=L_VALID=1 (A_ADDR=3, L_ADDR=7) held for 4 cycles -> grants A,L,A,L; D_Addr sequence 3,7,3,7 with D_EN=1 each cycle after the first.
REQ-037 ISSUE_EN with ISSUE_ADDR=5 -> BUSY=0x00000020 next cycle; L_VALID with L_ADDR=5 and L_DATA=0xDEADBEEF00000001 -> next cycle D_EN=1, D=that value, BUSY=0.
REQ-038 ISSUE_ADDR=9 and an accepted A_ADDR=9 in the same cycle, with BUSY[9] previously 1 -> BUSY[9] stays 1 and D_Addr=9 is written.
REQ-039 Only A_VALID=1 for 5 cycles -> A_READY=1 and L_READY=0 each cycle, 5 consecutive D_EN pulses.
REQ-040 Accept a transfer, then RESET=1 on the next edge -> D_EN=0, BUSY=0; first tie after reset is granted to A.
REQ-041 VALID low on both requesters for 3 cycles -> READY low, D_EN=0, D_Addr/D unchanged, pointer unchanged.
